// File: rtl/disp_pkg.sv
// Shared definitions for the keypad entry / multiplexed 7-segment display slice.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: NUM_POS, bcd_t, glyph constants SEG_0..SEG_9 / SEG_DASH / SEG_BLANK,
//           onehot_to_bcd() helper. Segment order is {g,f,e,d,c,b,a}, active-high.
package disp_pkg;

  localparam int NUM_POS = 4;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Index of the set bit; only meaningful when the caller has already
  // established that exactly one bit is set.
  function automatic bcd_t onehot_to_bcd(input logic [9:0] v);
    bcd_t r;
    r = '0;
    for (int k = 0; k < 10; k++) begin
      if (v[k]) r = bcd_t'(k);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD to 7-segment glyph decoder; codes 10..15 decode to blank.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_bcd - 4-bit BCD digit; o_seg - glyph {g,f,e,d,c,b,a}, active-high.
module seg7_encode
  import disp_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/keypad_display.sv
// Four-entry keypad shift buffer driving a time-multiplexed 4-position 7-segment display.
// Latency: buffer/count valid 1 cycle after a pulse; seg/an are registered 1 cycle behind the scan index.
// Backpressure: none; input events are never stalled, at full occupancy the oldest entry is overwritten.
// Ports: clk, rstn (async active-low); digit_pulse[9:0] one-hot digit event; clear empties the buffer;
//        seg[6:0] glyph {g,f,e,d,c,b,a}; an[3:0] one-hot position (an[0] rightmost); count[2:0] entries held.
// Option: define DISP_MASK_EN to add input mask, which shows a dash on every occupied position.
module keypad_display
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [9:0] digit_pulse,
  input  logic       clear,
`ifdef DISP_MASK_EN
  input  logic       mask,
`endif
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [2:0] count
);

  localparam int         PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [2:0] MAX_CNT    = 3'(NUM_POS);

  bcd_t          r_buf [NUM_POS];
  logic [2:0]    r_count;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_scan;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic          w_accept;
  bcd_t          w_bcd;
  logic          w_wrap;
  bcd_t          w_cur_bcd;
  logic [6:0]    w_glyph;
  logic          w_occupied;
  logic [6:0]    w_seg_nxt;

  // x & (x-1) clears the lowest set bit, so zero result with x != 0 means one-hot.
  assign w_accept = (digit_pulse != '0) && ((digit_pulse & (digit_pulse - 10'd1)) == '0);
  assign w_bcd    = onehot_to_bcd(digit_pulse);

  // Entry buffer: position 0 is the newest digit. clear has priority over a pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_POS; i++) r_buf[i] <= '0;
      r_count <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_POS; i++) r_buf[i] <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_buf[0] <= w_bcd;
      for (int i = 1; i < NUM_POS; i++) r_buf[i] <= r_buf[i-1];
      if (r_count != MAX_CNT) r_count <= r_count + 3'd1;
    end
  end

  // Scan prescaler and position index.
  assign w_wrap = (r_presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
      r_scan  <= '0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_scan  <= r_scan + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_cur_bcd  = r_buf[r_scan];
  assign w_occupied = ({1'b0, r_scan} < r_count);

  seg7_encode u_seg7_encode (
    .i_bcd (w_cur_bcd),
    .o_seg (w_glyph)
  );

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    if (w_occupied) begin
`ifdef DISP_MASK_EN
      w_seg_nxt = mask ? SEG_DASH : w_glyph;
`else
      w_seg_nxt = w_glyph;
`endif
    end
  end

  // seg and an are registered from the same scan index so they can never disagree.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seg <= SEG_BLANK;
      r_an  <= '0;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= 4'b0001 << r_scan;
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign count = r_count;

endmodule

// File: tb/tb_keypad_display.sv
// Self-checking bench for keypad_display with SCAN_DIV=4.
// The reference model keeps the entries in a queue (newest at the front) and
// derives the displayed position from the number of clock edges since reset.
module tb_keypad_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [9:0] digit_pulse = '0;
  logic       clear = 1'b0;
`ifdef DISP_MASK_EN
  logic       mask = 1'b0;
`endif
  logic [6:0] seg;
  logic [3:0] an;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  keypad_display #(.SCAN_DIV(SD)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .digit_pulse (digit_pulse),
    .clear       (clear),
`ifdef DISP_MASK_EN
    .mask        (mask),
`endif
    .seg         (seg),
    .an          (an),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic mask_now();
`ifdef DISP_MASK_EN
    return mask;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- reference model ----------------
  int         q[$];
  int         k = 0;
  logic [3:0] exp_an = '0;
  logic [6:0] exp_seg = '0;
  logic [2:0] exp_count = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      k = 0;
      exp_an = '0;
      exp_seg = '0;
      exp_count = '0;
    end else begin : upd
      int pos;
      pos = (k / SD) % 4;
      exp_an = 4'(1 << pos);
      if (pos < q.size()) exp_seg = mask_now() ? 7'b1000000 : glyph(q[pos]);
      else                exp_seg = 7'b0000000;
      if (clear) q.delete();
      else if ($countones(digit_pulse) == 1) begin
        q.push_front($clog2(digit_pulse));
        if (q.size() > 4) void'(q.pop_back());
      end
      exp_count = 3'(q.size());
      k++;
    end
  end

  // Drive-only helper: one single-cycle digit event followed by an idle cycle.
  task automatic pulse(input int d);
    @(negedge clk);
    digit_pulse = 10'(1 << d);
    @(negedge clk);
    digit_pulse = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({an, seg, count} !== 14'b0)
        $display("FAIL reset_hold an=%b seg=%b count=%0d required all zero", an, seg, count);
    end
    rstn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if (an !== 4'(1 << (c / 4)) || seg !== 7'b0 || count !== 3'd0) begin
        bad++;
        $display("FAIL idle_scan c=%0d an=%b seg=%b count=%0d required an=%b seg=0 count=0",
                 c, an, seg, count, 4'(1 << (c / 4)));
      end
    end
  endtask

  task automatic test_single_digit();
    @(negedge clk);
    digit_pulse = 10'b0000001000;
    @(negedge clk);
    digit_pulse = '0;
    total++;
    if (count !== 3'd1) begin
      bad++;
      $display("FAIL single_count count=%0d required 1", count);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if ({an, seg, count} !== {exp_an, exp_seg, exp_count}) begin
        bad++;
        $display("FAIL single_model an=%b/%b seg=%b/%b count=%0d/%0d", an, exp_an, seg, exp_seg, count, exp_count);
      end
      total++;
      if (seg !== ((an == 4'b0001) ? 7'b1001111 : 7'b0000000)) begin
        bad++;
        $display("FAIL single_glyph an=%b seg=%b", an, seg);
      end
    end
  endtask

  task automatic test_saturate();
    for (int d = 1; d <= 5; d++) begin
      pulse(d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if ({an, seg, count} !== {exp_an, exp_seg, exp_count}) begin
        bad++;
        $display("FAIL sat_model an=%b/%b seg=%b/%b count=%0d/%0d", an, exp_an, seg, exp_seg, count, exp_count);
      end
      total++;
      if (count !== 3'd4) begin
        bad++;
        $display("FAIL sat_count count=%0d required 4", count);
      end
      if (an == 4'b1000) begin
        total++;
        if (seg !== 7'b1011011) begin
          bad++;
          $display("FAIL sat_pos3 seg=%b required 1011011", seg);
        end
      end
      if (an == 4'b0001) begin
        total++;
        if (seg !== 7'b1101101) begin
          bad++;
          $display("FAIL sat_pos0 seg=%b required 1101101", seg);
        end
      end
    end
  endtask

  task automatic test_invalid();
    @(negedge clk);
    digit_pulse = 10'b0000000110;
    @(negedge clk);
    digit_pulse = 10'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if ({an, seg, count} !== {exp_an, exp_seg, exp_count} || count !== 3'd4) begin
        bad++;
        $display("FAIL invalid_model an=%b/%b seg=%b/%b count=%0d/%0d", an, exp_an, seg, exp_seg, count, exp_count);
      end
      if (an == 4'b0001) begin
        total++;
        if (seg !== 7'b1101101) begin
          bad++;
          $display("FAIL invalid_pos0 seg=%b required 1101101", seg);
        end
      end
    end
  endtask

  task automatic test_clear_wins();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pulse(1);
    pulse(2);
    total++;
    if (count !== 3'd2) begin
      bad++;
      $display("FAIL clear_pre count=%0d required 2", count);
    end
    @(negedge clk);
    clear = 1'b1;
    digit_pulse = 10'b0010000000;
    @(negedge clk);
    clear = 1'b0;
    digit_pulse = '0;
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL clear_count count=%0d required 0", count);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if (seg !== 7'b0 || count !== 3'd0 || {an, seg, count} !== {exp_an, exp_seg, exp_count}) begin
        bad++;
        $display("FAIL clear_blank an=%b/%b seg=%b/0 count=%0d/0", an, exp_an, seg, count);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++;
      if ({an, seg, count} !== {exp_an, exp_seg, exp_count}) begin
        bad++;
        $display("FAIL rand_model c=%0d an=%b/%b seg=%b/%b count=%0d/%0d", c, an, exp_an, seg, exp_seg, count, exp_count);
      end
      clear = 1'b0;
      digit_pulse = '0;
      case ($urandom_range(0, 9))
        0, 1, 2: digit_pulse = 10'(1 << $urandom_range(0, 9));
        3:       digit_pulse = 10'($urandom);
        4:       if ($urandom_range(0, 3) == 0) begin
                   clear = 1'b1;
                   digit_pulse = 10'(1 << $urandom_range(0, 9));
                 end
        default: digit_pulse = '0;
      endcase
    end
    @(negedge clk);
    clear = 1'b0;
    digit_pulse = '0;
  endtask

  task automatic test_reset_abort();
    pulse(6);
    pulse(8);
    repeat (5) @(negedge clk);
    digit_pulse = 10'b0000100000;
    rstn = 1'b0;
    #1;
    total++;
    if ({an, seg, count} !== 14'b0) begin
      bad++;
      $display("FAIL abort_async an=%b seg=%b count=%0d required all zero", an, seg, count);
    end
    @(negedge clk);
    digit_pulse = '0;
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (an !== 4'b0001 || seg !== 7'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL abort_release an=%b seg=%b count=%0d required 0001/0/0", an, seg, count);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if ({an, seg, count} !== {exp_an, exp_seg, exp_count}) begin
        bad++;
        $display("FAIL abort_model an=%b/%b seg=%b/%b count=%0d/%0d", an, exp_an, seg, exp_seg, count, exp_count);
      end
    end
  endtask

`ifdef DISP_MASK_EN
  task automatic test_mask();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pulse(9);
    pulse(9);
    mask = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if (seg !== ((an == 4'b0001 || an == 4'b0010) ? 7'b1000000 : 7'b0000000)
          || seg !== exp_seg) begin
        bad++;
        $display("FAIL mask_on an=%b seg=%b model=%b", an, seg, exp_seg);
      end
    end
    mask = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if (seg !== ((an == 4'b0001 || an == 4'b0010) ? 7'b1101111 : 7'b0000000)
          || seg !== exp_seg) begin
        bad++;
        $display("FAIL mask_off an=%b seg=%b model=%b", an, seg, exp_seg);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_digit();
    test_saturate();
    test_invalid();
    test_clear_wins();
    test_random();
    test_reset_abort();
`ifdef DISP_MASK_EN
    test_mask();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_display.md
KEYPAD_DISPLAY -- requirements
Module: keypad_display

Interface
REQ-001 SCAN_DIV, 50000, clocks per displayed position; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 digit_pulse  input  10  one-hot single-cycle digit event; bit k = digit k.
REQ-005 clear  input  1  single-cycle request to empty the entry buffer.
REQ-006 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
REQ-007 an  output  4  position select, one-hot, active-high, registered; an[0] = rightmost.
REQ-008 count  output  3  number of held entries, 0..4, registered.

Function
REQ-009 Accept digit_pulse only when exactly one bit is set; all-zero or multi-bit values are ignored, and the buffer is unchanged.
REQ-010 Convert an accepted one-hot value to 4-bit BCD (bit k -> k).
REQ-011 On accept: shift position n to n+1, load the new digit into position 0, and drop position 3; the buffer is valid the next cycle.
REQ-012 count increments on accept and saturates at 4; at 4 the oldest entry is discarded silently.
REQ-013 clear empties the buffer and sets count=0 the next cycle; clear wins over a simultaneous digit_pulse, which is dropped.
REQ-014 Prescaler counts 0..SCAN_DIV-1 and wraps; on wrap the scan index advances 0->1->2->3->0.
REQ-015 Each position is shown for exactly SCAN_DIV cycles, with no overlap between positions.
REQ-016 an = one-hot(scan index), registered; it changes one cycle after the prescaler wraps.
REQ-017 seg shows the standard 7-segment glyph for position scan index when that index < count; otherwise seg = 7'b0000000 (blank).
REQ-018 seg and an update in the same cycle; they are never mismatched.
REQ-019 BCD values 10..15, which are unreachable, SHALL decode to blank.
REQ-020 Display latency: a new entry appears on seg at the next visit of position 0 after the buffer update, +1 register cycle.

Reset
REQ-021 While rstn=0: seg=0, an=4'b0000, count=0, buffer all zeros, prescaler=0, scan index=0.
REQ-022 rstn asserted mid-scan or mid-entry SHALL abort immediately; no partial shift is retained.
REQ-023 First cycle after release: an=4'b0001, and seg is blank (count=0).

Configuration
REQ-024 Macro DISP_MASK_EN: when defined, add input port mask (1 bit), which holds its value between changes.
REQ-025 With mask=1, every occupied position shows a dash, seg=7'b1000000, and unoccupied positions stay blank.
REQ-026 Without DISP_MASK_EN: no mask port, and digits are always shown.

Structure
REQ-027 Shared package disp_pkg holds: NUM_POS=4, the BCD digit typedef (4 bits), the glyph constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK.
REQ-028 Sub-module seg7_encode: combinational BCD -> seg mapping, instantiated once on the scan path.

Verification (SCAN_DIV=4)
REQ-029 Reset, then no input -> an cycles 0001,0010,0100,1000 with 4 cycles each; seg=0 throughout; count=0.
REQ-030 Pulse digit_pulse=10'b0000001000 (digit 3) -> count=1; at an=0001 seg=7'b1001111; other positions show seg=0.
REQ-031 Enter 1,2,3,4,5 -> count=4; positions 3..0 show 2,3,4,5 (digit 1 dropped).
REQ-032 digit_pulse=10'b0000000110, then 10'b0 -> buffer and count unchanged.
REQ-033 clear and digit 7 in the same cycle, with count=2 -> count=0, all blank, digit 7 not stored.
REQ-034 With DISP_MASK_EN: enter 9,9 and mask=1 -> positions 0,1 show seg=7'b1000000 and positions 2,3 are blank; mask=0 -> positions 0,1 show 7'b1101111.
